// File: rtl/cp0_unit_if.sv
// CP0 request/response bundle between the pipeline (master) and the
// coprocessor-0 register block (slave).
interface cp0_unit_if;
    logic        read_en;
    logic [4:0]  read_addr;
    logic [31:0] read_data;
    logic        write_en;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [5:0]  hw_int;
    logic        exc_en;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_delay_slot;
    logic [31:0] exc_badvaddr;
    logic        eret;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        int_pending;

    modport master (
        output read_en, read_addr, write_en, write_addr, write_data, hw_int,
               exc_en, exc_code, exc_pc, exc_delay_slot, exc_badvaddr, eret,
        input  read_data, status, cause, epc, int_pending
    );

    modport slave (
        input  read_en, read_addr, write_en, write_addr, write_data, hw_int,
               exc_en, exc_code, exc_pc, exc_delay_slot, exc_badvaddr, eret,
        output read_data, status, cause, epc, int_pending
    );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor-0 register block: BadVAddr, Count, Compare, Status, Cause, EPC.
// Serves mfc0/mtc0, records exception entry and eret, raises int_pending.
// Build option: define CP0_TIMER_EN to include Count/Compare and the timer
// interrupt; without it those registers read 0 and TI is tied low.
module cp0_unit #(
    parameter int unsigned COUNT_DIV = 2
) (
    input logic       clk,
    input logic       rst,
    cp0_unit_if.slave bus
);
    localparam logic [31:0] STATUS_BEV   = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    logic [31:0] badvaddr;
    logic [31:0] epc_q;
    logic [7:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [4:0]  exc_code_q;
    logic [5:0]  hw_q;
    logic [1:0]  ip_sw;
    logic        ti;
    logic [7:0]  ip;
    logic [31:0] status_val;
    logic [31:0] cause_val;
    logic [31:0] rd_val;
    logic        wr_ok;
    logic        bypass;

    // A COUNT_DIV of 0 is meaningless; this branch is never meant to elaborate.
    if (COUNT_DIV < 1) begin : g_bad_count_div
    end

    // Exceptions and eret cancel a same-cycle mtc0 entirely.
    assign wr_ok  = bus.write_en & ~bus.exc_en & ~bus.eret;
    assign bypass = wr_ok & bus.read_en & (bus.write_addr == bus.read_addr);

`ifdef CP0_TIMER_EN
    localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [31:0]   count_q;
    logic [31:0]   compare_q;
    logic [PW-1:0] phase;
    logic          ti_q;

    assign ti = ti_q;

    // Divided Count tick, Compare match detection and sticky TI.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            compare_q <= '0;
            phase     <= '0;
            ti_q      <= 1'b0;
        end else begin
            if (wr_ok && bus.write_addr == 5'd9) begin
                count_q <= bus.write_data;
                phase   <= '0;
            end else if (phase == PW'(COUNT_DIV - 1)) begin
                count_q <= count_q + 32'd1;
                phase   <= '0;
            end else begin
                phase <= phase + PW'(1);
            end
            // A Compare write clears TI even when a match lands on the same edge.
            if (wr_ok && bus.write_addr == 5'd11) begin
                compare_q <= bus.write_data;
                ti_q      <= 1'b0;
            end else if (count_q == compare_q) begin
                ti_q <= 1'b1;
            end
        end
    end
`else
    assign ti = 1'b0;
`endif

    assign ip         = {hw_q[5] | ti, hw_q[4:0], ip_sw};
    assign status_val = STATUS_BEV | {16'b0, im, 6'b0, exl, ie};
    assign cause_val  = {bd, ti, 14'b0, ip, 1'b0, exc_code_q, 2'b0};

    assign bus.status      = status_val;
    assign bus.cause       = cause_val;
    assign bus.epc         = epc_q;
    assign bus.int_pending = ie & ~exl & |(ip & im);
    assign bus.read_data   = rd_val;

    // Read mux; a matching mtc0 forwards the post-write (masked) value.
    always_comb begin
        rd_val = '0;
        case (bus.read_addr)
            5'd8:  rd_val = badvaddr;
`ifdef CP0_TIMER_EN
            5'd9:  rd_val = count_q;
            5'd11: rd_val = compare_q;
`endif
            5'd12: rd_val = status_val;
            5'd13: rd_val = cause_val;
            5'd14: rd_val = epc_q;
            default: rd_val = '0;
        endcase
        if (bypass) begin
            case (bus.write_addr)
`ifdef CP0_TIMER_EN
                5'd9:  rd_val = bus.write_data;
                5'd11: rd_val = bus.write_data;
`endif
                5'd12: rd_val = STATUS_BEV | (bus.write_data & STATUS_WMASK);
                5'd13: rd_val = {cause_val[31:10], bus.write_data[9:8], cause_val[7:0]};
                5'd14: rd_val = bus.write_data;
                default: ;
            endcase
        end
        if (!bus.read_en) begin
            rd_val = '0;
        end
    end

    // Status/Cause/EPC/BadVAddr update: exception > eret > mtc0.
    always_ff @(posedge clk) begin
        if (rst) begin
            badvaddr   <= '0;
            epc_q      <= '0;
            im         <= '0;
            exl        <= 1'b0;
            ie         <= 1'b0;
            bd         <= 1'b0;
            exc_code_q <= '0;
            hw_q       <= '0;
            ip_sw      <= '0;
        end else begin
            hw_q <= bus.hw_int;
            if (bus.exc_en) begin
                // Nested exceptions keep the original return address and BD.
                if (!exl) begin
                    epc_q <= bus.exc_delay_slot ? bus.exc_pc - 32'd4 : bus.exc_pc;
                    bd    <= bus.exc_delay_slot;
                end
                exl        <= 1'b1;
                exc_code_q <= bus.exc_code;
                if (bus.exc_code == 5'd4 || bus.exc_code == 5'd5) begin
                    badvaddr <= bus.exc_badvaddr;
                end
            end else if (bus.eret) begin
                exl <= 1'b0;
            end else if (bus.write_en) begin
                case (bus.write_addr)
                    5'd12: begin
                        im  <= bus.write_data[15:8];
                        exl <= bus.write_data[1];
                        ie  <= bus.write_data[0];
                    end
                    5'd13: ip_sw <= bus.write_data[9:8];
                    5'd14: epc_q <= bus.write_data;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed scenarios plus randomized traffic
// checked against an architectural model of the CP0 registers.
module tb_cp0_unit;
    localparam int unsigned CDIV = 2;
`ifdef CP0_TIMER_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cp0_unit_if bus ();

    cp0_unit #(.COUNT_DIV(CDIV)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Architectural state: whole register words, Count as base + elapsed/CDIV.
    typedef struct packed {
        logic [31:0] status;
        logic [31:0] cause_sw;
        logic [31:0] epc;
        logic [31:0] bad;
        logic [31:0] count_base;
        logic [31:0] ncyc;
        logic [31:0] compare;
        logic        ti;
        logic [5:0]  hwq;
    } mstate_t;

    mstate_t m;
    int nvec = 0;
    int nerr = 0;

    function automatic mstate_t m_reset();
        mstate_t s;
        s = '0;
        s.status = 32'h0040_0000;
        return s;
    endfunction

    function automatic logic [31:0] m_count(input mstate_t s);
        return s.count_base + s.ncyc / CDIV;
    endfunction

    function automatic logic [31:0] m_cause(input mstate_t s);
        logic [31:0] c;
        c = s.cause_sw;
        c[30] = s.ti;
        c[15] = s.hwq[5] | s.ti;
        c[14:10] = s.hwq[4:0];
        return c;
    endfunction

    function automatic logic [31:0] m_read(input mstate_t s, input logic [4:0] a);
        case (a)
            5'd8:  return s.bad;
            5'd9:  return TIMER_EN ? m_count(s) : 32'd0;
            5'd11: return TIMER_EN ? s.compare : 32'd0;
            5'd12: return s.status;
            5'd13: return m_cause(s);
            5'd14: return s.epc;
            default: return 32'd0;
        endcase
    endfunction

    function automatic mstate_t m_write(input mstate_t s, input logic [4:0] a, input logic [31:0] d);
        mstate_t n;
        n = s;
        case (a)
            5'd9: if (TIMER_EN) begin n.count_base = d; n.ncyc = 0; end
            5'd11: if (TIMER_EN) begin n.compare = d; n.ti = 1'b0; end
            5'd12: n.status = 32'h0040_0000 | (d & 32'h0000_FF03);
            5'd13: n.cause_sw = (s.cause_sw & ~32'h0000_0300) | (d & 32'h0000_0300);
            5'd14: n.epc = d;
            default: ;
        endcase
        return n;
    endfunction

    function automatic logic m_int(input mstate_t s);
        logic [31:0] c;
        c = m_cause(s);
        return s.status[0] & ~s.status[1] & (|(c[15:8] & s.status[15:8]));
    endfunction

    function automatic mstate_t m_next(input mstate_t s);
        mstate_t n;
        n = s;
        n.hwq = bus.hw_int;
        if (TIMER_EN) begin
            n.ncyc = s.ncyc + 1;
            if (m_count(s) == s.compare) n.ti = 1'b1;
        end
        if (bus.exc_en) begin
            if (!s.status[1]) begin
                n.epc = bus.exc_delay_slot ? bus.exc_pc - 32'd4 : bus.exc_pc;
                n.cause_sw[31] = bus.exc_delay_slot;
            end
            n.status[1] = 1'b1;
            n.cause_sw[6:2] = bus.exc_code;
            if (bus.exc_code == 5'd4 || bus.exc_code == 5'd5) n.bad = bus.exc_badvaddr;
        end else if (bus.eret) begin
            n.status[1] = 1'b0;
        end else if (bus.write_en) begin
            n = m_write(n, bus.write_addr, bus.write_data);
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.read_en = 1'b0;
        bus.read_addr = '0;
        bus.write_en = 1'b0;
        bus.write_addr = '0;
        bus.write_data = '0;
        bus.exc_en = 1'b0;
        bus.exc_code = '0;
        bus.exc_pc = '0;
        bus.exc_delay_slot = 1'b0;
        bus.exc_badvaddr = '0;
        bus.eret = 1'b0;
    endtask

    task automatic set_wr(input logic [4:0] a, input logic [31:0] d);
        bus.write_en = 1'b1;
        bus.write_addr = a;
        bus.write_data = d;
    endtask

    task automatic set_rd(input logic [4:0] a);
        bus.read_en = 1'b1;
        bus.read_addr = a;
    endtask

    task automatic set_exc(input logic [31:0] pc, input logic ds, input logic [4:0] code,
                           input logic [31:0] bva);
        bus.exc_en = 1'b1;
        bus.exc_pc = pc;
        bus.exc_delay_slot = ds;
        bus.exc_code = code;
        bus.exc_badvaddr = bva;
    endtask

    // Check outputs against the model mid-cycle, then clock and advance the model.
    task automatic step();
        logic [31:0] exp_rd;
        mstate_t bp;
        @(negedge clk);
        if (!rst) begin
            exp_rd = '0;
            if (bus.read_en) begin
                if (bus.write_en && !bus.exc_en && !bus.eret && bus.write_addr == bus.read_addr) begin
                    bp = m_write(m, bus.write_addr, bus.write_data);
                    exp_rd = m_read(bp, bus.read_addr);
                end else begin
                    exp_rd = m_read(m, bus.read_addr);
                end
            end
            chk("read_data", bus.read_data, exp_rd);
            chk("status", bus.status, m.status);
            chk("cause", bus.cause, m_cause(m));
            chk("epc", bus.epc, m.epc);
            chk("int_pending", 32'(bus.int_pending), 32'(m_int(m)));
        end
        @(posedge clk);
        m = rst ? m_reset() : m_next(m);
        #1;
    endtask

    function automatic logic [4:0] pick_addr();
        case ($urandom_range(0, 6))
            0: return 5'd8;
            1: return 5'd9;
            2: return 5'd11;
            3: return 5'd12;
            4: return 5'd13;
            5: return 5'd14;
            default: return 5'($urandom);
        endcase
    endfunction

    task automatic rand_inputs();
        bus.read_en = ($urandom_range(0, 3) != 0);
        bus.read_addr = pick_addr();
        bus.write_en = ($urandom_range(0, 2) == 0);
        bus.write_addr = ($urandom_range(0, 1) != 0) ? bus.read_addr : pick_addr();
        bus.write_data = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                     : $urandom;
        bus.exc_en = ($urandom_range(0, 12) == 0);
        bus.exc_code = ($urandom_range(0, 1) != 0) ? 5'(4 + $urandom_range(0, 1)) : 5'($urandom);
        bus.exc_pc = $urandom;
        bus.exc_delay_slot = 1'($urandom_range(0, 1));
        bus.exc_badvaddr = $urandom;
        bus.eret = ($urandom_range(0, 10) == 0);
        if ($urandom_range(0, 7) == 0) bus.hw_int = 6'($urandom);
    endtask

    initial begin
        m = m_reset();
        idle();
        bus.hw_int = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset value and Status write masking
        set_rd(5'd12);
        #1 chk("rst_status_rd", bus.read_data, 32'h0040_0000);
        step();
        idle();
        set_wr(5'd12, 32'hFFFF_FFFF);
        step();
        idle();
        set_rd(5'd12);
        #1 chk("status_mask_rd", bus.read_data, 32'h0040_FF03);
        step();

        // Exception entry from a delay slot with an address error
        idle();
        set_wr(5'd12, 32'h0000_FF01);
        step();
        idle();
        set_exc(32'hBFC0_0100, 1'b1, 5'd4, 32'h0000_1235);
        step();
        idle();
        chk("exc_epc", bus.epc, 32'hBFC0_00FC);
        chk("exc_bd_code", bus.cause & 32'h8000_007C, 32'h8000_0010);
        chk("exc_exl", 32'(bus.status[1]), 32'd1);
        set_rd(5'd8);
        #1 chk("exc_badvaddr", bus.read_data, 32'h0000_1235);
        step();
        idle();
        set_exc(32'h0000_0010, 1'b0, 5'd0, 32'h0);
        step();
        idle();
        chk("nested_epc", bus.epc, 32'hBFC0_00FC);
        chk("nested_bd_code", bus.cause & 32'h8000_007C, 32'h8000_0000);

        // Priority: exception beats eret beats mtc0; no bypass when cancelled
        bus.eret = 1'b1;
        step();
        idle();
        set_exc(32'h0000_0200, 1'b0, 5'd2, 32'hDEAD_BEEF);
        bus.eret = 1'b1;
        set_wr(5'd14, 32'h55);
        set_rd(5'd14);
        #1 chk("cancel_no_bypass", bus.read_data, 32'hBFC0_00FC);
        step();
        idle();
        chk("prio_epc", bus.epc, 32'h0000_0200);
        chk("prio_exl", 32'(bus.status[1]), 32'd1);
        set_rd(5'd8);
        #1 chk("prio_badvaddr_kept", bus.read_data, 32'h0000_1235);
        step();
        idle();
        bus.eret = 1'b1;
        step();
        idle();
        set_wr(5'd14, 32'h55);
        set_rd(5'd14);
        #1 chk("epc_bypass", bus.read_data, 32'h55);
        step();
        idle();
        chk("epc_written", bus.epc, 32'h55);

`ifdef CP0_TIMER_EN
        // Timer: Compare=3, Count=0, TI appears on the edge after the match
        set_wr(5'd11, 32'd3);
        step();
        idle();
        chk("ti_cleared_by_compare", 32'(bus.cause[30]), 32'd0);
        set_wr(5'd9, 32'd0);
        step();
        idle();
        for (int i = 0; i < 6; i++) step();
        set_rd(5'd9);
        #1 chk("count_after_6", bus.read_data, 32'd3);
        chk("ti_before_match_edge", 32'(bus.cause[30]), 32'd0);
        step();
        idle();
        chk("ti_set", 32'(bus.cause[30]), 32'd1);
        chk("ti_int_pending", 32'(bus.int_pending), 32'd1);
        set_wr(5'd11, 32'h100);
        step();
        idle();
        chk("ti_clear", 32'(bus.cause[30]), 32'd0);
        chk("ti_clear_int", 32'(bus.int_pending), 32'd0);
`endif

        // Hardware interrupt latency and EXL masking
        set_wr(5'd12, 32'h0000_0401);
        step();
        idle();
        bus.hw_int = 6'b000001;
        #1 chk("hw_int_not_yet", 32'(bus.int_pending), 32'd0);
        step();
        chk("hw_int_pending", 32'(bus.int_pending), 32'd1);
        set_wr(5'd12, 32'h0000_0403);
        step();
        idle();
        chk("exl_masks_int", 32'(bus.int_pending), 32'd0);
        bus.eret = 1'b1;
        step();
        idle();
        chk("eret_unmasks_int", 32'(bus.int_pending), 32'd1);
        bus.hw_int = '0;
        step();

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            step();
        end

        // Reset in the middle of traffic overrides all requests
        rand_inputs();
        bus.exc_en = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        chk("midrst_status", bus.status, 32'h0040_0000);
        chk("midrst_cause", bus.cause, 32'h0);
        chk("midrst_epc", bus.epc, 32'h0);
        set_rd(5'd8);
        #1 chk("midrst_badvaddr", bus.read_data, 32'h0);
        step();

        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
